// File: rtl/des_pkg.sv
// des_pkg: DES index tables, S-boxes, decrypt shift schedule, FSM codes
// and the bit-permutation helpers used by the iterative decrypt engine.
package des_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // right-rotation amounts, subkeys come out K16 first
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5,
    4, 5, 6, 7, 8, 9,
    8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32, 1
  };

  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17,
    1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9,
    19, 13, 30, 6, 22, 11, 4, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,
    1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
    7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29,
    21, 13, 5, 28, 20, 12, 4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5,
    3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8,
    16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // row-major nibbles: entry (row*16+col) counted from the MSB
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] r);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = r[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0] b;
    logic [5:0] idx;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      b = x[47-6*k -: 6];
      idx = {b[5], b[0], b[4:1]};
      y[31-4*k -: 4] = SBOX[k][255-4*idx -: 4];
    end
    return y;
  endfunction

  function automatic logic [27:0] rotr28(
    input logic [27:0] x,
    input logic [1:0] s
  );
    logic [27:0] y;
    case (s)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_f.sv
// des_f: DES round function, E expansion, key mix, S-boxes and P.
// Purely combinational; one instance serves all sixteen rounds.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] f
);

  assign f = p_perm(sbox_sub(e_exp(r) ^ subkey));

endmodule

// File: rtl/des_iter_decrypt.sv
// des_iter_decrypt: one-round-per-clock DES decryption with optional
// CBC chaining and valid/ready handshakes on both sides.
module des_iter_decrypt
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cipher_text,
  input  logic [63:0] cipher_key,
  input  logic        cbc_en,
  input  logic        iv_load,
  input  logic [63:0] iv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plain_text,
  output logic        busy
);

  logic [1:0]  state;
  logic [31:0] l, r;
  logic [27:0] c, d;
  logic [3:0]  rnd;
  logic [63:0] ct_hold;
  logic [63:0] chain;
  logic        cbc_q;

  logic        st_idle, st_round, st_done;
  logic [27:0] c_n, d_n;
  logic [47:0] subkey;
  logic [31:0] f_out, r_n;
  logic [63:0] res, x_ip;
  logic [55:0] cd_pc1;

  assign st_idle  = (state == S_IDLE);
  assign st_round = (state == S_ROUND);
  assign st_done  = (state == S_DONE);

  assign in_ready = st_idle && !iv_load;
  assign busy     = st_round || st_done;

  assign c_n    = rotr28(c, DEC_SHIFT[rnd]);
  assign d_n    = rotr28(d, DEC_SHIFT[rnd]);
  assign subkey = pc2({c_n, d_n});

  des_f u_f (
    .r      (r),
    .subkey (subkey),
    .f      (f_out)
  );

  assign r_n = l ^ f_out;
  // last round's halves go out swapped: {R16, L16}
  assign res    = fp({r_n, r});
  assign x_ip   = ip(cipher_text);
  assign cd_pc1 = pc1(cipher_key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      l          <= '0;
      r          <= '0;
      c          <= '0;
      d          <= '0;
      rnd        <= '0;
      ct_hold    <= '0;
      chain      <= '0;
      cbc_q      <= 1'b0;
      out_valid  <= 1'b0;
      plain_text <= '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (iv_load) begin
            chain <= iv;
          end else if (in_valid) begin
            {l, r}  <= x_ip;
            {c, d}  <= cd_pc1;
            ct_hold <= cipher_text;
            cbc_q   <= cbc_en;
            rnd     <= '0;
            state   <= S_ROUND;
          end
        end
        st_round: begin
          c   <= c_n;
          d   <= d_n;
          l   <= r;
          r   <= r_n;
          rnd <= rnd + 4'd1;
          if (rnd == 4'd15) begin
            state      <= S_DONE;
            out_valid  <= 1'b1;
            plain_text <= cbc_q ? (res ^ chain) : res;
            if (cbc_q) chain <= ct_hold;
          end
        end
        st_done: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_decrypt.sv
// tb_des_iter_decrypt: directed DES decrypt vectors scored against a
// forward-schedule DES model with a CBC chain and expected-output queue.
module tb_des_iter_decrypt;
  import des_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] cipher_text;
  logic [63:0] cipher_key;
  logic        cbc_en;
  logic        iv_load;
  logic [63:0] iv;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plain_text;
  logic        busy;

  des_iter_decrypt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cipher_text (cipher_text),
    .cipher_key  (cipher_key),
    .cbc_en      (cbc_en),
    .iv_load     (iv_load),
    .iv          (iv),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .plain_text  (plain_text),
    .busy        (busy)
  );

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] P2 = 64'hFEDCBA9876543210;
  localparam int LS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int          checks;
  int          failures;
  int          cyc;
  bit          ov_prev;
  logic [63:0] m_chain;
  logic [63:0] exp_q [$];
  int          acc_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // sel: 0 IP, 1 FP, 2 PC1, 3 PC2, 4 E, 5 P; result right-aligned
  function automatic logic [63:0] tperm(input int sel, input logic [63:0] x,
                                        input int wi);
    logic [63:0] y;
    int n, t;
    y = '0;
    n = (sel < 2) ? 64 : (sel == 2) ? 56 : (sel == 5) ? 32 : 48;
    for (int i = 0; i < n; i++) begin
      case (sel)
        0: t = IP_T[i];
        1: t = FP_T[i];
        2: t = PC1_T[i];
        3: t = PC2_T[i];
        4: t = E_T[i];
        default: t = P_T[i];
      endcase
      y = {y[62:0], x[wi-t]};
    end
    return y;
  endfunction

  function automatic logic [31:0] m_sbox(input logic [47:0] x);
    logic [31:0] y;
    int v, row, col;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      v   = int'((x >> (42 - 6 * k)) & 48'h3F);
      row = ((v >> 4) & 2) | (v & 1);
      col = (v >> 1) & 15;
      y = (y << 4) | (32'(SBOX[k] >> (4 * (63 - (row * 16 + col)))) & 32'hF);
    end
    return y;
  endfunction

  // textbook DES: left-rotate key schedule, reversed subkeys for decrypt
  function automatic logic [63:0] m_crypt(input logic [63:0] blk,
                                          input logic [63:0] key,
                                          input bit dec);
    logic [47:0] ks [16];
    logic [63:0] t;
    logic [27:0] kc, kd;
    logic [31:0] hl, hr, fo;
    logic [47:0] k;
    t  = tperm(2, key, 64);
    kc = t[55:28];
    kd = t[27:0];
    for (int i = 0; i < 16; i++) begin
      kc = (kc << LS[i]) | (kc >> (28 - LS[i]));
      kd = (kd << LS[i]) | (kd >> (28 - LS[i]));
      t  = tperm(3, {8'h00, kc, kd}, 56);
      ks[i] = t[47:0];
    end
    t  = tperm(0, blk, 64);
    hl = t[63:32];
    hr = t[31:0];
    for (int i = 0; i < 16; i++) begin
      k  = dec ? ks[15-i] : ks[i];
      t  = tperm(4, {32'h0, hr}, 32);
      t  = tperm(5, {32'h0, m_sbox(t[47:0] ^ k)}, 32);
      fo = hl ^ t[31:0];
      hl = hr;
      hr = fo;
    end
    return tperm(1, {hr, hl}, 64);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev <= 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("plain_text", plain_text, exp_q[0]);
          chk("in_ready_in_done", 64'(in_ready), 64'd0);
          chk("busy_in_done", 64'(busy), 64'd1);
          if (!ov_prev) chk("latency", 64'(cyc - acc_q[0]), 64'd16);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      ov_prev <= out_valid && !out_ready;
    end
  end

  task automatic send(input logic [63:0] ct, input logic [63:0] key,
                      input logic cbc, output int waited);
    logic [63:0] e;
    in_valid    = 1'b1;
    cipher_text = ct;
    cipher_key  = key;
    cbc_en      = cbc;
    waited      = 0;
    for (int w = 1; w <= 40; w++) begin
      @(negedge clk);
      if (in_ready) begin
        waited = w;
        break;
      end
    end
    if (waited == 0) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      e = m_crypt(ct, key, 1'b1);
      if (cbc) begin
        e = e ^ m_chain;
        m_chain = ct;
      end
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("done_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    m_chain = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int w;
    logic [63:0] ct1, ct2, ct3, ctb, civ;
    logic [63:0] tv_ct [3];
    logic [63:0] tv_key [3];
    tv_ct[0]  = 64'h0000000000000000;
    tv_ct[1]  = 64'hFFFFFFFFFFFFFFFF;
    tv_ct[2]  = 64'h0123456789ABCDEF;
    tv_key[0] = K2;
    tv_key[1] = K1;
    tv_key[2] = 64'hFEDCBA9876543210;
    in_valid = 0; cipher_text = 0; cipher_key = 0; cbc_en = 0;
    iv_load = 0; iv = 0; out_ready = 1; rst_n = 0;
    checks = 0; failures = 0; m_chain = 0;

    chk("model_dec_v1", m_crypt(64'h85E813540F0AB405, K1, 1'b1), P1);
    chk("model_enc_v1", m_crypt(P1, K1, 1'b0), 64'h85E813540F0AB405);
    chk("model_dec_v2", m_crypt(64'h0, K2, 1'b1), 64'h8787878787878787);

    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_plain_text", plain_text, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    send(64'h85E813540F0AB405, K1, 1'b0, w);
    wait_done();
    send(64'h0, K2, 1'b0, w);
    wait_done();

    iv = 64'h1234567890ABCDEF;
    iv_load = 1'b1;
    m_chain = iv;
    @(posedge clk);
    #1;
    iv_load = 1'b0;
    ct1 = m_crypt(P1 ^ 64'h1234567890ABCDEF, K1, 1'b0);
    send(ct1, K1, 1'b1, w);
    wait_done();
    ct2 = m_crypt(P2 ^ ct1, K1, 1'b0);
    send(ct2, K1, 1'b1, w);
    wait_done();

    send(tv_ct[0], tv_key[0], 1'b0, w);
    for (int i = 1; i < 3; i++) begin
      send(tv_ct[i], tv_key[i], 1'b0, w);
      chk("throughput", 64'(w), 64'd18);
    end
    wait_done();

    out_ready = 1'b0;
    send(tv_ct[1], K2, 1'b0, w);
    repeat (17) @(negedge clk);
    chk("bp_valid", 64'(out_valid), 64'd1);
    ctb = 64'hDEADBEEFCAFEF00D;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; cipher_text = ctb; cipher_key = K1; cbc_en = 1'b0;
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    send(ctb, K1, 1'b0, w);
    chk("ready_after_hs", 64'(w), 64'd1);
    wait_done();

    civ = m_crypt(P1 ^ 64'hA5A5A5A55A5A5A5A, K1, 1'b0);
    iv = 64'hA5A5A5A55A5A5A5A;
    iv_load = 1'b1;
    in_valid = 1'b1; cipher_text = civ; cipher_key = K1; cbc_en = 1'b1;
    @(negedge clk);
    chk("ivl_in_ready", 64'(in_ready), 64'd0);
    m_chain = iv;
    @(posedge clk);
    #1;
    iv_load = 1'b0;
    send(civ, K1, 1'b1, w);
    chk("ivl_accept_next", 64'(w), 64'd1);
    wait_done();

    send(ct2, K1, 1'b1, w);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    m_chain = '0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    ct3 = m_crypt(P2, K2, 1'b0);
    send(ct3, K2, 1'b1, w);
    wait_done();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
